ddc_lane_unpack_gain: RTL



---
 rtl/ddc_unpack_pkg.sv | 21 ++
 rtl/ddc_sat_shift.sv | 51 +++++
 rtl/ddc_lane_unpack_gain.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ddc_unpack_pkg.sv
// Shared constants and helpers for the DDC lane unpack / gain block.
package ddc_unpack_pkg;

    localparam int DEF_LANE_WIDTH    = 24;
    localparam int DEF_IQ_DATA_WIDTH = 16;
    localparam int CNT_W             = 16;

    // Slot index of a component inside tdata: I of channel c at 2c, Q at 2c+1.
    function automatic int comp_idx(input int ch, input int iq);
        return 2 * ch + iq;
    endfunction

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/ddc_sat_shift.sv
// Single-component arithmetic right shift with optional round-half-up and
// signed saturation to IQ_DATA_WIDTH. Rounding is compiled in by
// DDC_UNPACK_ROUND_EN; without it the shift truncates toward -inf.
module ddc_sat_shift
    import ddc_unpack_pkg::*;
#(
    parameter int LANE_WIDTH    = DEF_LANE_WIDTH,
    parameter int IQ_DATA_WIDTH = DEF_IQ_DATA_WIDTH,
    parameter int SHIFT_W       = 4
) (
    input  logic [LANE_WIDTH-1:0]    i_x,
    input  logic [SHIFT_W-1:0]       i_shift,
    output logic [IQ_DATA_WIDTH-1:0] o_y,
    output logic                     o_sat
);

    localparam logic signed [LANE_WIDTH:0] MAXV = (LANE_WIDTH+1)'(sat_max(IQ_DATA_WIDTH));
    localparam logic signed [LANE_WIDTH:0] MINV = (LANE_WIDTH+1)'(sat_min(IQ_DATA_WIDTH));

    // One guard bit so the rounding offset can never wrap the sum.
    logic signed [LANE_WIDTH:0] w_ext;
    logic signed [LANE_WIDTH:0] w_off;
    logic signed [LANE_WIDTH:0] w_sum;
    logic signed [LANE_WIDTH:0] w_shr;

    assign w_ext = {i_x[LANE_WIDTH-1], i_x};

`ifdef DDC_UNPACK_ROUND_EN
    localparam logic [LANE_WIDTH:0] ONE = (LANE_WIDTH+1)'(1);
    assign w_off = (i_shift == '0) ? '0 : (ONE << (i_shift - SHIFT_W'(1)));
`else
    assign w_off = '0;
`endif

    assign w_sum = w_ext + w_off;
    assign w_shr = w_sum >>> i_shift;

    // Clip to the output range and flag any clipping.
    always_comb begin
        o_sat = 1'b0;
        o_y   = w_shr[IQ_DATA_WIDTH-1:0];
        if (w_shr > MAXV) begin
            o_y   = MAXV[IQ_DATA_WIDTH-1:0];
            o_sat = 1'b1;
        end else if (w_shr < MINV) begin
            o_y   = MINV[IQ_DATA_WIDTH-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/ddc_lane_unpack_gain.sv
// DDC output interface: per-beat source select (bw20/bw02), NUM_CH I/Q lane
// unpack, run-time gain shift with saturation, and a show-ahead output FIFO.
// Build option: DDC_UNPACK_ROUND_EN enables round-half-up before the shift.
module ddc_lane_unpack_gain
    import ddc_unpack_pkg::*;
#(
    parameter int IQ_DATA_WIDTH = DEF_IQ_DATA_WIDTH,
    parameter int LANE_WIDTH    = DEF_LANE_WIDTH,
    parameter int NUM_CH        = 2,
    parameter int SHIFT_W       = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [SHIFT_W-1:0]                gain_cfg,
    input  logic                              bw_sel,
    input  logic [2*NUM_CH*LANE_WIDTH-1:0]    bw20_data_tdata,
    input  logic                              bw20_data_tvalid,
    input  logic [2*NUM_CH*LANE_WIDTH-1:0]    bw02_data_tdata,
    input  logic                              bw02_data_tvalid,
    output logic [NUM_CH*IQ_DATA_WIDTH-1:0]   out_i,
    output logic [NUM_CH*IQ_DATA_WIDTH-1:0]   out_q,
    output logic                              out_tvalid,
    input  logic                              out_tready,
    input  logic                              clr_cnt,
    output logic [CNT_W-1:0]                  sat_cnt,
    output logic [CNT_W-1:0]                  ovf_cnt
);

    localparam int NCOMP = 2 * NUM_CH;
    localparam int DW    = NCOMP * LANE_WIDTH;
    localparam int OW    = NUM_CH * IQ_DATA_WIDTH;
    localparam int SMAX  = LANE_WIDTH - IQ_DATA_WIDTH;
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [SHIFT_W-1:0] SMAX_V  = SHIFT_W'(SMAX);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [AW:0]        FULL_V  = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [OW-1:0] i;
        logic [OW-1:0] q;
    } beat_t;

    // vld_pipe[0]: stage-1 beat valid, vld_pipe[1]: stage-2 beat valid
    logic [1:0]         r_vld_pipe;
    logic [DW-1:0]      r_s1_data;
    logic [SHIFT_W-1:0] r_s1_shift;
    beat_t              r_s2;
    logic               r_s2_sat;

    // Stage 1: capture source, data and clamped shift together so each beat
    // carries its own settings.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_pipe <= '0;
            r_s1_data  <= '0;
            r_s1_shift <= '0;
        end else begin
            r_vld_pipe[0] <= bw_sel ? bw02_data_tvalid : bw20_data_tvalid;
            r_vld_pipe[1] <= r_vld_pipe[0];
            r_s1_data     <= bw_sel ? bw02_data_tdata : bw20_data_tdata;
            r_s1_shift    <= (gain_cfg > SMAX_V) ? SMAX_V : gain_cfg;
        end
    end

    logic [NUM_CH-1:0][IQ_DATA_WIDTH-1:0] w_i;
    logic [NUM_CH-1:0][IQ_DATA_WIDTH-1:0] w_q;
    logic [NCOMP-1:0]                     w_sat;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ddc_sat_shift #(
            .LANE_WIDTH   (LANE_WIDTH),
            .IQ_DATA_WIDTH(IQ_DATA_WIDTH),
            .SHIFT_W      (SHIFT_W)
        ) u_i (
            .i_x    (r_s1_data[comp_idx(c, 0)*LANE_WIDTH +: LANE_WIDTH]),
            .i_shift(r_s1_shift),
            .o_y    (w_i[c]),
            .o_sat  (w_sat[comp_idx(c, 0)])
        );
        ddc_sat_shift #(
            .LANE_WIDTH   (LANE_WIDTH),
            .IQ_DATA_WIDTH(IQ_DATA_WIDTH),
            .SHIFT_W      (SHIFT_W)
        ) u_q (
            .i_x    (r_s1_data[comp_idx(c, 1)*LANE_WIDTH +: LANE_WIDTH]),
            .i_shift(r_s1_shift),
            .o_y    (w_q[c]),
            .o_sat  (w_sat[comp_idx(c, 1)])
        );
    end

    // Stage 2: register scaled components and the beat-level saturation flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2     <= '0;
            r_s2_sat <= 1'b0;
        end else begin
            r_s2.i   <= w_i;
            r_s2.q   <= w_q;
            r_s2_sat <= |w_sat;
        end
    end

    beat_t          r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [AW:0]    r_cnt;
    logic           w_full;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;

    assign w_full     = (r_cnt == FULL_V);
    assign out_tvalid = (r_cnt != '0);
    assign w_pop      = out_tvalid && out_tready;
    // A pop frees the slot in the same cycle, so full+pop still accepts.
    assign w_push     = r_vld_pipe[1] && (!w_full || w_pop);
    assign w_drop     = r_vld_pipe[1] && w_full && !w_pop;

    assign out_i = r_mem[r_rd].i;
    assign out_q = r_mem[r_rd].q;

    // Output FIFO: circular buffer with occupancy count, show-ahead read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= r_s2;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    logic [CNT_W-1:0] r_sat_cnt;
    logic [CNT_W-1:0] r_ovf_cnt;

    // Sticky-at-max event counters; clear wins over a same-cycle event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sat_cnt <= '0;
            r_ovf_cnt <= '0;
        end else if (clr_cnt) begin
            r_sat_cnt <= '0;
            r_ovf_cnt <= '0;
        end else begin
            if (r_vld_pipe[1] && r_s2_sat && (r_sat_cnt != CNT_MAX))
                r_sat_cnt <= r_sat_cnt + CNT_W'(1);
            if (w_drop && (r_ovf_cnt != CNT_MAX))
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
        end
    end

    assign sat_cnt = r_sat_cnt;
    assign ovf_cnt = r_ovf_cnt;

endmodule
